// File: rtl/mvm_pkg.sv
// Shared types and bus-width helpers for the MVM request arbiter slice.
package mvm_pkg;

  localparam int N_REQ_DEF = 2;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  typedef logic [$clog2(N_REQ_DEF)-1:0] tag_t;

  function automatic int busKxWidth(input int r, input int c, input int wK, input int wX);
    return r * c * wK + c * wX;
  endfunction

  function automatic int busYWidth(input int r, input int wY);
    return r * wY;
  endfunction

endpackage

// File: rtl/mvm_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each issued-but-unreturned request.
module mvm_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] headData,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wrPtr_q, wrPtr_d;
  logic [AW:0]  rdPtr_q, rdPtr_d;
  logic         doPush, doPop;

  assign empty    = (wrPtr_q == rdPtr_q);
  assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign headData = mem_q[rdPtr_q[AW-1:0]];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/mvm_req_arbiter.sv
// Round-robin sharing of one MVM engine between N_REQ requesters, with in-order
// result routing through a tag FIFO and a credit limit on outstanding requests.
module mvm_req_arbiter
  import mvm_pkg::*;
#(
  parameter int R            = 8,
  parameter int C            = 8,
  parameter int W_X          = 8,
  parameter int W_K          = 8,
  parameter int W_Y_OUT      = 32,
  parameter int N_REQ        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int W_BUS_KX     = busKxWidth(R, C, W_K, W_X),
  parameter int W_BUS_Y      = busYWidth(R, W_Y_OUT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 s_valid,
  output logic [N_REQ-1:0]                 s_ready,
  input  logic [N_REQ-1:0][W_BUS_KX-1:0]   s_data,
  output logic                             eng_valid,
  input  logic                             eng_ready,
  output logic [W_BUS_KX-1:0]              eng_kx,
  input  logic                             eng_y_valid,
  output logic                             eng_y_ready,
  input  logic [W_BUS_Y-1:0]               eng_y,
  output logic [N_REQ-1:0]                 m_valid,
  input  logic [N_REQ-1:0]                 m_ready,
  output logic [W_BUS_Y-1:0]               m_data,
  output logic                             err
);

  localparam int TW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       rrPtr_q, rrPtr_d;
  logic [CW-1:0]       inflight_q, inflight_d;
  logic [W_BUS_KX-1:0] engKx_q, engKx_d;
  logic                err_q, err_d;

  logic                grantFound;
  logic [TW-1:0]       grantIdx;
  logic [TW-1:0]       scanIdx;
  logic                accept, retire, drop, creditOk;
  logic                fifoFull, fifoEmpty;
  logic [TW-1:0]       headTag;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    scanIdx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scanIdx = TW'((int'(rrPtr_q) + k) % N_REQ);
      if (!grantFound && s_valid[scanIdx]) begin
        grantFound = 1'b1;
        grantIdx   = scanIdx;
      end
    end
  end

  assign m_data      = eng_y;
  assign eng_y_ready = !rst && (fifoEmpty ? eng_y_valid : m_ready[headTag]);
  assign retire      = eng_y_valid && eng_y_ready && !fifoEmpty;
  assign drop        = eng_y_valid && eng_y_ready && fifoEmpty;

  always_comb begin
    m_valid = '0;
    if (!rst && eng_y_valid && !fifoEmpty) m_valid[headTag] = 1'b1;
  end

  // A retiring result frees its slot for an accept in the same cycle.
  assign creditOk = ((inflight_q < CW'(MAX_INFLIGHT)) && !fifoFull) || retire;
  assign accept   = |(s_valid & s_ready);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = ISSUE;
      ISSUE:   if (eng_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = '0;
    eng_valid = 1'b0;
    case (state_q)
      IDLE:    if (!rst && creditOk && grantFound) s_ready[grantIdx] = 1'b1;
      ISSUE:   eng_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rrPtr_d    = rrPtr_q;
    engKx_d    = engKx_q;
    inflight_d = inflight_q;
    err_d      = err_q || drop;
    if (accept) begin
      engKx_d = s_data[grantIdx];
      rrPtr_d = (grantIdx == TW'(N_REQ - 1)) ? '0 : grantIdx + 1'b1;
    end
    case ({accept, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q    <= '0;
      engKx_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      engKx_q    <= engKx_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign eng_kx = engKx_q;
  assign err    = err_q;

  mvm_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (TW)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .pushData (grantIdx),
    .pop      (retire),
    .headData (headTag),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_mvm_req_arbiter.sv
// Directed bench for mvm_req_arbiter; the bench plays the engine and computes results with a software MVM.
module tb_mvm_req_arbiter;

  localparam int R       = 8;
  localparam int C       = 8;
  localparam int W_X     = 8;
  localparam int W_K     = 8;
  localparam int W_Y_OUT = 32;
  localparam int N_REQ   = 2;
  localparam int MAX_INF = 4;
  localparam int W_KX    = R * C * W_K + C * W_X;
  localparam int W_Y     = R * W_Y_OUT;

  logic                         clk;
  logic                         rst;
  logic [N_REQ-1:0]             s_valid;
  logic [N_REQ-1:0]             s_ready;
  logic [N_REQ-1:0][W_KX-1:0]   s_data;
  logic                         eng_valid;
  logic                         eng_ready;
  logic [W_KX-1:0]              eng_kx;
  logic                         eng_y_valid;
  logic                         eng_y_ready;
  logic [W_Y-1:0]               eng_y;
  logic [N_REQ-1:0]             m_valid;
  logic [N_REQ-1:0]             m_ready;
  logic [W_Y-1:0]               m_data;
  logic                         err;

  int passCount = 0;
  int checkCount = 0;

  mvm_req_arbiter #(
    .R(R), .C(C), .W_X(W_X), .W_K(W_K), .W_Y_OUT(W_Y_OUT),
    .N_REQ(N_REQ), .MAX_INFLIGHT(MAX_INF)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_kx(eng_kx),
    .eng_y_valid(eng_y_valid), .eng_y_ready(eng_y_ready), .eng_y(eng_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W_KX-1:0] makeKx(input int seed);
    logic [W_KX-1:0] kx;
    kx = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        kx[C*W_X + (r*C + c)*W_K +: W_K] = W_K'(((r*3 + c*5 + seed) % 15) - 7);
    for (int c = 0; c < C; c++)
      kx[c*W_X +: W_X] = W_X'(((c + seed) % 9) - 4);
    return kx;
  endfunction

  function automatic logic [W_KX-1:0] makeIdentityKx();
    logic [W_KX-1:0] kx;
    kx = '0;
    for (int r = 0; r < R; r++)
      kx[C*W_X + (r*C + r)*W_K +: W_K] = W_K'(1);
    for (int c = 0; c < C; c++)
      kx[c*W_X +: W_X] = W_X'(c + 1);
    return kx;
  endfunction

  // Signed K*x accumulated into W_Y_OUT-bit elements.
  function automatic logic [W_Y-1:0] mvmModel(input logic [W_KX-1:0] kx);
    logic [W_Y-1:0]        y;
    logic signed [W_K-1:0] kv;
    logic signed [W_X-1:0] xv;
    int                    acc;
    y = '0;
    for (int r = 0; r < R; r++) begin
      acc = 0;
      for (int c = 0; c < C; c++) begin
        kv  = kx[C*W_X + (r*C + c)*W_K +: W_K];
        xv  = kx[c*W_X +: W_X];
        acc = acc + int'(kv) * int'(xv);
      end
      y[r*W_Y_OUT +: W_Y_OUT] = W_Y_OUT'(acc);
    end
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic resetDut();
    rst         = 1'b1;
    s_valid     = '0;
    s_data      = '0;
    eng_ready   = 1'b0;
    eng_y_valid = 1'b0;
    eng_y       = '0;
    m_ready     = '0;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    s_valid     = 2'b11;
    s_data      = '0;
    eng_ready   = 1'b0;
    eng_y_valid = 1'b0;
    eng_y       = '0;
    m_ready     = 2'b11;
    tick();
    tick();
    checkCount++;
    if (s_ready !== 2'b00) $display("[TB] FAIL reset_s_ready: got %b expected 00", s_ready); else passCount++;
    checkCount++;
    if (eng_valid !== 1'b0) $display("[TB] FAIL reset_eng_valid: got %b expected 0", eng_valid); else passCount++;
    checkCount++;
    if (eng_kx !== '0) $display("[TB] FAIL reset_eng_kx: got %h expected 0", eng_kx); else passCount++;
    checkCount++;
    if (m_valid !== 2'b00) $display("[TB] FAIL reset_m_valid: got %b expected 00", m_valid); else passCount++;
    checkCount++;
    if (eng_y_ready !== 1'b0) $display("[TB] FAIL reset_eng_y_ready: got %b expected 0", eng_y_ready); else passCount++;
    checkCount++;
    if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passCount++;
    rst = 1'b0;
    s_valid = '0;
    m_ready = '0;
    settle();
  endtask

  task automatic test_identity();
    logic [W_KX-1:0] kxId;
    logic [W_Y-1:0]  yExp;
    resetDut();
    kxId = makeIdentityKx();
    yExp = '0;
    for (int r = 0; r < R; r++) yExp[r*W_Y_OUT +: W_Y_OUT] = W_Y_OUT'(r + 1);
    s_data[0] = kxId;
    s_data[1] = makeKx(3);
    s_valid   = 2'b01;
    settle();
    checkCount++;
    if (s_ready !== 2'b01) $display("[TB] FAIL id_s_ready: got %b expected 01", s_ready); else passCount++;
    tick();
    s_valid = '0;
    settle();
    checkCount++;
    if (eng_valid !== 1'b1) $display("[TB] FAIL id_eng_valid: got %b expected 1", eng_valid); else passCount++;
    checkCount++;
    if (eng_kx !== kxId) $display("[TB] FAIL id_eng_kx: got %h expected %h", eng_kx, kxId); else passCount++;
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    settle();
    checkCount++;
    if (eng_valid !== 1'b0) $display("[TB] FAIL id_eng_valid_drop: got %b expected 0", eng_valid); else passCount++;
    eng_y_valid = 1'b1;
    eng_y       = mvmModel(eng_kx);
    m_ready     = 2'b11;
    settle();
    checkCount++;
    if (m_valid !== 2'b01) $display("[TB] FAIL id_m_valid: got %b expected 01", m_valid); else passCount++;
    checkCount++;
    if (m_data !== yExp) $display("[TB] FAIL id_m_data: got %h expected %h", m_data, yExp); else passCount++;
    checkCount++;
    if (eng_y_ready !== 1'b1) $display("[TB] FAIL id_eng_y_ready: got %b expected 1", eng_y_ready); else passCount++;
    tick();
    eng_y_valid = 1'b0;
    settle();
    checkCount++;
    if (m_valid !== 2'b00) $display("[TB] FAIL id_m_valid_after: got %b expected 00", m_valid); else passCount++;
  endtask

  task automatic test_alternate();
    logic [W_KX-1:0]  issued [4];
    logic [N_REQ-1:0] expOneHot;
    logic [W_Y-1:0]   yExp;
    resetDut();
    s_valid   = 2'b11;
    eng_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      s_data[0] = makeKx(2*n);
      s_data[1] = makeKx(2*n + 1);
      settle();
      expOneHot = N_REQ'(1 << (n % 2));
      issued[n] = makeKx(2*n + (n % 2));
      checkCount++;
      if (s_ready !== expOneHot) $display("[TB] FAIL alt_grant%0d: got %b expected %b", n, s_ready, expOneHot); else passCount++;
      tick();
      settle();
      checkCount++;
      if (eng_kx !== issued[n]) $display("[TB] FAIL alt_eng_kx%0d: got %h expected %h", n, eng_kx, issued[n]); else passCount++;
      checkCount++;
      if (eng_valid !== 1'b1) $display("[TB] FAIL alt_eng_valid%0d: got %b expected 1", n, eng_valid); else passCount++;
      tick();
    end
    s_valid = '0;
    m_ready = 2'b11;
    for (int n = 0; n < 4; n++) begin
      yExp        = mvmModel(issued[n]);
      eng_y_valid = 1'b1;
      eng_y       = yExp;
      settle();
      expOneHot = N_REQ'(1 << (n % 2));
      checkCount++;
      if (m_valid !== expOneHot) $display("[TB] FAIL alt_route%0d: got %b expected %b", n, m_valid, expOneHot); else passCount++;
      checkCount++;
      if (m_data !== yExp) $display("[TB] FAIL alt_m_data%0d: got %h expected %h", n, m_data, yExp); else passCount++;
      tick();
    end
    eng_y_valid = 1'b0;
    settle();
  endtask

  task automatic test_credit();
    int accepts;
    resetDut();
    s_data[0]   = makeKx(9);
    s_valid     = 2'b01;
    eng_ready   = 1'b1;
    accepts     = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      settle();
      if (s_valid[0] && s_ready[0]) accepts++;
      tick();
    end
    checkCount++;
    if (accepts != 4) $display("[TB] FAIL credit_accepts: got %0d expected 4", accepts); else passCount++;
    settle();
    checkCount++;
    if (s_ready !== 2'b00) $display("[TB] FAIL credit_blocked: got %b expected 00", s_ready); else passCount++;
    eng_y_valid = 1'b1;
    eng_y       = mvmModel(makeKx(9));
    m_ready     = 2'b01;
    settle();
    checkCount++;
    if (s_ready !== 2'b01) $display("[TB] FAIL credit_same_cycle: got %b expected 01", s_ready); else passCount++;
    checkCount++;
    if (m_valid !== 2'b01) $display("[TB] FAIL credit_m_valid: got %b expected 01", m_valid); else passCount++;
    tick();
    eng_y_valid = 1'b0;
    settle();
    checkCount++;
    if (eng_valid !== 1'b1) $display("[TB] FAIL credit_reissue: got %b expected 1", eng_valid); else passCount++;
    tick();
    settle();
    checkCount++;
    if (s_ready !== 2'b00) $display("[TB] FAIL credit_full_again: got %b expected 00", s_ready); else passCount++;
    s_valid = '0;
    for (int n = 0; n < 4; n++) begin
      eng_y_valid = 1'b1;
      settle();
      checkCount++;
      if (m_valid !== 2'b01) $display("[TB] FAIL credit_drain%0d: got %b expected 01", n, m_valid); else passCount++;
      tick();
    end
    settle();
    checkCount++;
    if (m_valid !== 2'b00) $display("[TB] FAIL credit_empty: got %b expected 00", m_valid); else passCount++;
    checkCount++;
    if (err !== 1'b0) $display("[TB] FAIL credit_err: got %b expected 0", err); else passCount++;
    eng_y_valid = 1'b0;
    settle();
  endtask

  task automatic test_back_to_back_hol();
    logic [W_Y-1:0] y0, y1;
    resetDut();
    eng_ready = 1'b1;
    s_data[0] = makeKx(20);
    s_data[1] = makeKx(21);
    y0        = mvmModel(makeKx(20));
    y1        = mvmModel(makeKx(21));
    s_valid   = 2'b01;
    settle();
    checkCount++;
    if (s_ready !== 2'b01) $display("[TB] FAIL hol_grant0: got %b expected 01", s_ready); else passCount++;
    tick();
    s_valid = 2'b10;
    tick();
    settle();
    checkCount++;
    if (s_ready !== 2'b10) $display("[TB] FAIL hol_grant1: got %b expected 10", s_ready); else passCount++;
    tick();
    s_valid = '0;
    tick();
    m_ready     = 2'b10;
    eng_y_valid = 1'b1;
    eng_y       = y0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      settle();
      checkCount++;
      if (eng_y_ready !== 1'b0) $display("[TB] FAIL hol_stall_ready%0d: got %b expected 0", cyc, eng_y_ready); else passCount++;
      checkCount++;
      if (m_valid !== 2'b01) $display("[TB] FAIL hol_stall_m_valid%0d: got %b expected 01", cyc, m_valid); else passCount++;
      tick();
    end
    m_ready = 2'b11;
    settle();
    checkCount++;
    if (m_valid !== 2'b01) $display("[TB] FAIL hol_first_route: got %b expected 01", m_valid); else passCount++;
    checkCount++;
    if (m_data !== y0) $display("[TB] FAIL hol_first_data: got %h expected %h", m_data, y0); else passCount++;
    checkCount++;
    if (eng_y_ready !== 1'b1) $display("[TB] FAIL hol_release: got %b expected 1", eng_y_ready); else passCount++;
    tick();
    eng_y = y1;
    settle();
    checkCount++;
    if (m_valid !== 2'b10) $display("[TB] FAIL hol_second_route: got %b expected 10", m_valid); else passCount++;
    checkCount++;
    if (m_data !== y1) $display("[TB] FAIL hol_second_data: got %h expected %h", m_data, y1); else passCount++;
    tick();
    eng_y_valid = 1'b0;
    settle();
  endtask

  task automatic test_err();
    resetDut();
    eng_y_valid = 1'b1;
    eng_y       = mvmModel(makeKx(5));
    m_ready     = 2'b11;
    settle();
    checkCount++;
    if (eng_y_ready !== 1'b1) $display("[TB] FAIL err_discard_ready: got %b expected 1", eng_y_ready); else passCount++;
    checkCount++;
    if (m_valid !== 2'b00) $display("[TB] FAIL err_no_m_valid: got %b expected 00", m_valid); else passCount++;
    checkCount++;
    if (err !== 1'b0) $display("[TB] FAIL err_before: got %b expected 0", err); else passCount++;
    tick();
    eng_y_valid = 1'b0;
    settle();
    checkCount++;
    if (err !== 1'b1) $display("[TB] FAIL err_set: got %b expected 1", err); else passCount++;
    tick();
    tick();
    tick();
    checkCount++;
    if (err !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", err); else passCount++;
    checkCount++;
    if (eng_y_ready !== 1'b0) $display("[TB] FAIL err_idle_ready: got %b expected 0", eng_y_ready); else passCount++;
    rst = 1'b1;
    tick();
    checkCount++;
    if (err !== 1'b0) $display("[TB] FAIL err_cleared: got %b expected 0", err); else passCount++;
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid();
    resetDut();
    s_data[0] = makeKx(30);
    s_data[1] = makeKx(31);
    s_valid   = 2'b01;
    eng_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      settle();
      checkCount++;
      if (s_ready !== 2'b01) $display("[TB] FAIL mid_accept%0d: got %b expected 01", n, s_ready); else passCount++;
      tick();
      if (n == 2) eng_ready = 1'b0;
      settle();
      checkCount++;
      if (eng_valid !== 1'b1) $display("[TB] FAIL mid_issue%0d: got %b expected 1", n, eng_valid); else passCount++;
      if (n < 2) tick();
    end
    s_valid = 2'b11;
    rst     = 1'b1;
    tick();
    settle();
    checkCount++;
    if (s_ready !== 2'b00) $display("[TB] FAIL mid_s_ready: got %b expected 00", s_ready); else passCount++;
    checkCount++;
    if (eng_valid !== 1'b0) $display("[TB] FAIL mid_eng_valid: got %b expected 0", eng_valid); else passCount++;
    checkCount++;
    if (eng_kx !== '0) $display("[TB] FAIL mid_eng_kx: got %h expected 0", eng_kx); else passCount++;
    checkCount++;
    if (m_valid !== 2'b00) $display("[TB] FAIL mid_m_valid: got %b expected 00", m_valid); else passCount++;
    checkCount++;
    if (eng_y_ready !== 1'b0) $display("[TB] FAIL mid_eng_y_ready: got %b expected 0", eng_y_ready); else passCount++;
    checkCount++;
    if (err !== 1'b0) $display("[TB] FAIL mid_err: got %b expected 0", err); else passCount++;
    rst = 1'b0;
    settle();
    checkCount++;
    if (s_ready !== 2'b01) $display("[TB] FAIL mid_regrant: got %b expected 01", s_ready); else passCount++;
    tick();
    settle();
    checkCount++;
    if (eng_kx !== makeKx(30)) $display("[TB] FAIL mid_regrant_kx: got %h expected %h", eng_kx, makeKx(30)); else passCount++;
    s_valid = '0;
    eng_y_valid = 1'b1;
    m_ready = 2'b11;
    settle();
    checkCount++;
    if (m_valid !== 2'b01) $display("[TB] FAIL mid_tags_dropped: got %b expected 01", m_valid); else passCount++;
    tick();
    eng_y_valid = 1'b0;
    settle();
  endtask

  initial begin
    $display("[TB] starting mvm_req_arbiter bench");
    test_reset();
    test_identity();
    test_alternate();
    test_credit();
    test_back_to_back_hol();
    test_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
